invader_march: RTL and testbench
================================

Name: invader_march

Overview:
Formation-movement controller for the invader wave. It consumes the level-scaled divided clock (`clkout`) from the speed divider and advances the formation one cell per rising edge. It reverses direction and drops one row at the playfield edges, and flags landing. When every invader is destroyed it issues the one-cycle active-low next-level pulse that drives the divider's `Pn` input.

Parameters:
- COLS, 8, formation columns; column i sits at `x_pos + i`.
- GRID_W, 16, playfield width in cells (valid x 0..GRID_W-1).
- Y_LAND, 7, row at which the formation has landed.
- X_START, 0, x_pos loaded at reset and after wave clear.

Ports:
- clkin  in  1  system clock
- reset  in  1  synchronous, active-high reset
- step_clk  in  1  divided clock from speed divider, synchronous to clkin
- freeze  in  1  1 = ignore step ticks (pause/game over)
- alive_mask  in  COLS  bit i = column i has a live invader
- x_pos  out  5  signed formation left coordinate (-COLS+1..GRID_W-1)
- y_pos  out  3  formation row, 0 = top
- dir  out  1  1 = moving right, 0 = moving left
- step_pulse  out  1  one-cycle strobe per executed step (sound/animation)
- lvl_n  out  1  active-low one-cycle next-level pulse → divider Pn
- landed  out  1  sticky; formation reached Y_LAND

Behaviour:
- Reset (sync, active-high) values: x_pos=X_START, y_pos=0, dir=1, step_pulse=0, lvl_n=1, landed=0, state=S_RIGHT, step_q<=step_clk (no spurious tick if step_clk is high at release).
- tick = step_clk & ~step_q & ~freeze. It is acted on at the same clkin edge, so outputs change one cycle after step_clk is sampled high.
- lo/hi = index of lowest/highest set bit of alive_mask (combinational).
- States: S_RIGHT, S_LEFT, S_CLEAR, S_LANDED.
- S_RIGHT on tick:
  - If x_pos+hi >= GRID_W-1: y_pos+1, dir=0, go S_LEFT, x unchanged.
  - Else x_pos+1.
- S_LEFT on tick:
  - If x_pos+lo <= 0: y_pos+1, dir=1, go S_RIGHT, x unchanged.
  - Else x_pos-1.
- step_pulse=1 for exactly the cycle following any executed tick (move or drop).
- Drop reaching y_pos==Y_LAND → S_LANDED.
  - landed=1, held until reset.
  - Ticks ignored; lvl_n stays 1.
- alive_mask==0 in S_RIGHT/S_LEFT → S_CLEAR.
  - lvl_n=0 for exactly one cycle.
  - x_pos=X_START, y_pos=0, dir=1.
- S_CLEAR holds (ticks ignored, lvl_n=1) until alive_mask!=0, then → S_RIGHT next cycle. One pulse per wave, since the divider increments every cycle Pn is low.
- Priority: reset > wave clear > landing > tick. A tick coinciding with alive_mask==0 is discarded.
- Last drop to Y_LAND with alive_mask!=0 → landed, even if the mask clears later.
- freeze does not block wave-clear detection.
- Edge test uses >=/<= so shrinking masks never overshoot. x arithmetic is 5-bit signed, and x_pos+hi/lo is sign-extended to 6 bits.

Decomposition:
- Package invader_pkg holds:
  - state enum (S_RIGHT, S_LEFT, S_CLEAR, S_LANDED);
  - default GRID_W, COLS, Y_LAND;
  - x_pos signed typedef.
- One sub-module, col_extent: COLS-bit mask → lo, hi, empty (priority encoders), purely combinational.

Test Plan:
1. Reset, mask=8'hFF, 8 step_clk rising edges → x_pos 0→8, y=0. 9th edge → x=8, y=1, dir=0, step_pulse=1 each step.
2. mask=8'h3C (lo=2, hi=5), start moving left from x=0 → x reaches -2. Next tick drops: y+1, dir=1, x=-2.
3. Run mask=8'h01 until y_pos=7 → landed=1 and stays 1. Further ticks leave x/y unchanged. Clearing the mask gives no lvl_n pulse.
4. Mid-march, mask→0 on the same cycle as a tick → lvl_n low exactly 1 cycle, x=0, y=0, dir=1, tick discarded. Mask held 0 for 10 cycles → no further pulse. Mask=8'hFF → S_RIGHT, marching resumes.
5. freeze=1 across 5 step_clk edges → x/y/step_pulse unchanged. Release → next rising edge steps.
6. step_clk high at reset release, then reset asserted mid-march at x=5,y=3 → no tick at release. All outputs at reset values one cycle after reset is sampled.

Source files
------------

// File: rtl/invader_pkg.sv
// ---------------------------------------------------------------------------
// invader_pkg
// Shared types and default geometry for the invader formation controller.
//   march_state_t : formation movement state
//   xpos_t        : signed 5-bit formation left coordinate
//   DEF_*         : default playfield geometry used as parameter defaults
// ---------------------------------------------------------------------------
package invader_pkg;

    localparam int DEF_COLS    = 8;
    localparam int DEF_GRID_W  = 16;
    localparam int DEF_Y_LAND  = 7;
    localparam int DEF_X_START = 0;

    localparam int XPOS_W = 5;
    localparam int YPOS_W = 3;

    typedef logic signed [XPOS_W-1:0] xpos_t;

    typedef enum logic [1:0] {
        S_RIGHT  = 2'd0,
        S_LEFT   = 2'd1,
        S_CLEAR  = 2'd2,
        S_LANDED = 2'd3
    } march_state_t;

endpackage : invader_pkg

// File: rtl/invader_march_col_extent.sv
// ---------------------------------------------------------------------------
// col_extent
// Finds the lowest and highest live column of the formation.
//   mask_i  : bit i set = column i still has a live invader
//   lo_o    : index of the lowest set bit (0 when mask is empty)
//   hi_o    : index of the highest set bit (0 when mask is empty)
//   empty_o : 1 when no column is alive
// Purely combinational.
// ---------------------------------------------------------------------------
module col_extent #(
    parameter int COLS = invader_pkg::DEF_COLS,
    parameter int IDXW = $clog2(COLS)
) (
    input  logic [COLS-1:0] mask_i,
    output logic [IDXW-1:0] lo_o,
    output logic [IDXW-1:0] hi_o,
    output logic            empty_o
);

    always_comb begin
        lo_o = '0;
        hi_o = '0;
        // Scan downward so the last hit is the lowest set bit.
        for (int i = COLS - 1; i >= 0; i--) begin
            if (mask_i[i]) lo_o = IDXW'(i);
        end
        // Scan upward so the last hit is the highest set bit.
        for (int i = 0; i < COLS; i++) begin
            if (mask_i[i]) hi_o = IDXW'(i);
        end
    end

    assign empty_o = ~|mask_i;

endmodule : col_extent

// File: rtl/invader_march.sv
// ---------------------------------------------------------------------------
// invader_march
// Formation movement controller. Steps the invader block one cell per rising
// edge of the divided step clock, bounces off the playfield edges with a
// one-row drop, flags landing, and emits a one-cycle active-low next-level
// pulse when the wave is cleared.
//   clkin      : system clock
//   reset      : synchronous active-high reset
//   step_clk   : divided step clock (synchronous to clkin)
//   freeze     : 1 = ignore step ticks
//   alive_mask : bit i = column i alive
//   x_pos      : signed formation left coordinate
//   y_pos      : formation row, 0 = top
//   dir        : 1 = moving right
//   step_pulse : one-cycle strobe after each executed step
//   lvl_n      : active-low one-cycle next-level pulse
//   landed     : sticky landing flag
// ---------------------------------------------------------------------------
module invader_march
    import invader_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int GRID_W  = DEF_GRID_W,
    parameter int Y_LAND  = DEF_Y_LAND,
    parameter int X_START = DEF_X_START
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              step_clk,
    input  logic              freeze,
    input  logic [COLS-1:0]   alive_mask,
    output logic signed [4:0] x_pos,
    output logic [2:0]        y_pos,
    output logic              dir,
    output logic              step_pulse,
    output logic              lvl_n,
    output logic              landed
);

    localparam int IDXW = $clog2(COLS);
    localparam logic signed [5:0] RIGHT_LIM = 6'(GRID_W - 1);

    march_state_t state_q;
    xpos_t        x_pos_q;
    logic [2:0]   y_pos_q;
    logic         dir_q;
    logic         step_pulse_q;
    logic         lvl_n_q;
    logic         landed_q;
    logic         step_q;

    logic [IDXW-1:0]   lo;
    logic [IDXW-1:0]   hi;
    logic              empty;
    logic              tick;
    logic signed [5:0] x_ext;
    logic signed [5:0] right_sum;
    logic signed [5:0] left_sum;
    logic              at_right;
    logic              at_left;
    logic [2:0]        y_pos_d;

    col_extent #(.COLS(COLS), .IDXW(IDXW)) u_extent (
        .mask_i  (alive_mask),
        .lo_o    (lo),
        .hi_o    (hi),
        .empty_o (empty)
    );

    // Rising edge of the step clock, gated by freeze.
    assign tick = step_clk & ~step_q & ~freeze;

    // Edge tests in 6-bit signed so negative x never wraps. >= / <= keeps
    // a shrinking mask from overshooting the playfield.
    assign x_ext     = {x_pos_q[4], x_pos_q};
    assign right_sum = x_ext + $signed(6'(hi));
    assign left_sum  = x_ext + $signed(6'(lo));
    assign at_right  = (right_sum >= RIGHT_LIM);
    assign at_left   = (left_sum <= 6'sd0);
    assign y_pos_d   = y_pos_q + 3'd1;

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q      <= S_RIGHT;
            x_pos_q      <= xpos_t'(X_START);
            y_pos_q      <= '0;
            dir_q        <= 1'b1;
            step_pulse_q <= 1'b0;
            lvl_n_q      <= 1'b1;
            landed_q     <= 1'b0;
            // Seeding with the live level suppresses a tick at release.
            step_q       <= step_clk;
        end else begin
            step_q       <= step_clk;
            step_pulse_q <= 1'b0;
            lvl_n_q      <= 1'b1;
            case (state_q)
                S_RIGHT, S_LEFT: begin
                    if (empty) begin
                        // Wave clear wins over any coincident tick.
                        state_q <= S_CLEAR;
                        lvl_n_q <= 1'b0;
                        x_pos_q <= xpos_t'(X_START);
                        y_pos_q <= '0;
                        dir_q   <= 1'b1;
                    end else if (tick) begin
                        step_pulse_q <= 1'b1;
                        if ((state_q == S_RIGHT) ? at_right : at_left) begin
                            y_pos_q <= y_pos_d;
                            dir_q   <= (state_q == S_LEFT);
                            if (y_pos_d == 3'(Y_LAND)) begin
                                state_q  <= S_LANDED;
                                landed_q <= 1'b1;
                            end else begin
                                state_q <= (state_q == S_RIGHT) ? S_LEFT : S_RIGHT;
                            end
                        end else if (state_q == S_RIGHT) begin
                            x_pos_q <= x_pos_q + 5'sd1;
                        end else begin
                            x_pos_q <= x_pos_q - 5'sd1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (!empty) state_q <= S_RIGHT;
                end
                S_LANDED: begin
                    landed_q <= 1'b1;
                end
                default: state_q <= S_RIGHT;
            endcase
        end
    end

    assign x_pos      = x_pos_q;
    assign y_pos      = y_pos_q;
    assign dir        = dir_q;
    assign step_pulse = step_pulse_q;
    assign lvl_n      = lvl_n_q;
    assign landed     = landed_q;

endmodule : invader_march

// File: tb/tb_invader_march.sv
// ---------------------------------------------------------------------------
// tb_invader_march
// Self-checking bench for invader_march: directed scenarios against constant
// expectations plus a randomized run against a behavioural model of the
// formation (integer position, row, direction and flags).
// ---------------------------------------------------------------------------
module tb_invader_march;

    localparam int GRID_W = 16;
    localparam int Y_LAND = 7;

    logic              clkin = 1'b0;
    logic              reset = 1'b1;
    logic              step_clk = 1'b0;
    logic              freeze = 1'b0;
    logic [7:0]        alive_mask = 8'hFF;
    logic signed [4:0] x_pos;
    logic [2:0]        y_pos;
    logic              dir;
    logic              step_pulse;
    logic              lvl_n;
    logic              landed;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    int m_x, m_y;
    bit m_dir, m_pulse, m_lvl, m_landed, m_wait, m_prev;

    invader_march dut (
        .clkin      (clkin),
        .reset      (reset),
        .step_clk   (step_clk),
        .freeze     (freeze),
        .alive_mask (alive_mask),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .dir        (dir),
        .step_pulse (step_pulse),
        .lvl_n      (lvl_n),
        .landed     (landed)
    );

    always #5 clkin = ~clkin;

    wire [11:0] obs = {x_pos, y_pos, dir, step_pulse, lvl_n, landed};

    function automatic logic [11:0] pack(input int x, input int y, input bit d,
                                         input bit p, input bit l, input bit ld);
        logic [4:0] xs;
        logic [2:0] ys;
        xs = 5'(x);
        ys = 3'(y);
        return {xs, ys, d, p, l, ld};
    endfunction

    function automatic logic [11:0] model_vec();
        return pack(m_x, m_y, m_dir, m_pulse, m_lvl, m_landed);
    endfunction

    // Reference: what the formation does at one clkin edge given these inputs.
    task automatic model_step(input bit rst, input bit sc, input bit fr, input logic [7:0] mask);
        bit t;
        int lo, hi;
        if (rst) begin
            m_x = 0; m_y = 0; m_dir = 1; m_pulse = 0; m_lvl = 1;
            m_landed = 0; m_wait = 0; m_prev = sc;
            return;
        end
        t = sc && !m_prev && !fr;
        m_prev  = sc;
        m_pulse = 0;
        m_lvl   = 1;
        if (m_landed) begin
        end else if (m_wait) begin
            if (mask != 0) m_wait = 0;
        end else if (mask == 0) begin
            m_wait = 1; m_lvl = 0; m_x = 0; m_y = 0; m_dir = 1;
        end else if (t) begin
            lo = -1; hi = 0;
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) begin
                    if (lo < 0) lo = i;
                    hi = i;
                end
            end
            m_pulse = 1;
            if (m_dir) begin
                if (m_x + hi >= GRID_W - 1) begin m_y++; m_dir = 0; end
                else m_x++;
            end else begin
                if (m_x + lo <= 0) begin m_y++; m_dir = 1; end
                else m_x--;
            end
            if (m_y == Y_LAND) m_landed = 1;
        end
    endtask

    task automatic drive_cycle(input bit rst, input bit sc, input bit fr, input logic [7:0] mask);
        @(negedge clkin);
        reset = rst; step_clk = sc; freeze = fr; alive_mask = mask;
        model_step(rst, sc, fr, mask);
        @(posedge clkin);
        #1;
    endtask

    task automatic do_reset();
        drive_cycle(1, 0, 0, 8'hFF);
        drive_cycle(1, 0, 0, 8'hFF);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (obs !== pack(0, 0, 1, 0, 1, 0))
            $display("FAIL reset_values: got %h expected %h", obs, pack(0, 0, 1, 0, 1, 0));
        else n_pass++;
        drive_cycle(0, 0, 0, 8'hFF);
        n_checks++;
        if (obs !== pack(0, 0, 1, 0, 1, 0))
            $display("FAIL reset_release: got %h expected %h", obs, pack(0, 0, 1, 0, 1, 0));
        else n_pass++;
    endtask

    task automatic test_march_right();
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(0, 1, 0, 8'hFF);
            n_checks++;
            if (obs !== pack(i, 0, 1, 1, 1, 0))
                $display("FAIL march_right step %0d: got %h expected %h", i, obs, pack(i, 0, 1, 1, 1, 0));
            else n_pass++;
            drive_cycle(0, 0, 0, 8'hFF);
            n_checks++;
            if (obs !== pack(i, 0, 1, 0, 1, 0))
                $display("FAIL march_right pulse_clear %0d: got %h expected %h", i, obs, pack(i, 0, 1, 0, 1, 0));
            else n_pass++;
        end
        drive_cycle(0, 1, 0, 8'hFF);
        n_checks++;
        if (obs !== pack(8, 1, 0, 1, 1, 0))
            $display("FAIL right_edge_drop: got %h expected %h", obs, pack(8, 1, 0, 1, 1, 0));
        else n_pass++;
        drive_cycle(0, 0, 0, 8'hFF);
    endtask

    // Continues from the right-edge drop: mask 3C has lo=2, so x stops at -2.
    task automatic test_left_edge();
        for (int i = 1; i <= 10; i++) begin
            drive_cycle(0, 1, 0, 8'h3C);
            n_checks++;
            if (obs !== pack(8 - i, 1, 0, 1, 1, 0))
                $display("FAIL left_march %0d: got %h expected %h", i, obs, pack(8 - i, 1, 0, 1, 1, 0));
            else n_pass++;
            drive_cycle(0, 0, 0, 8'h3C);
        end
        drive_cycle(0, 1, 0, 8'h3C);
        n_checks++;
        if (obs !== pack(-2, 2, 1, 1, 1, 0))
            $display("FAIL left_edge_drop: got %h expected %h", obs, pack(-2, 2, 1, 1, 1, 0));
        else n_pass++;
        drive_cycle(0, 0, 0, 8'h3C);
    endtask

    task automatic test_landing();
        int k;
        do_reset();
        drive_cycle(0, 0, 0, 8'h01);
        for (k = 0; k < 300; k++) begin
            drive_cycle(0, 1, 0, 8'h01);
            if (landed === 1'b1) break;
            drive_cycle(0, 0, 0, 8'h01);
        end
        // 7 drops, each preceded by 15 moves.
        n_checks++;
        if (k !== 111)
            $display("FAIL landing_tick_count: got %0d expected %0d", k, 111);
        else n_pass++;
        n_checks++;
        if (obs !== pack(15, 7, 0, 1, 1, 1))
            $display("FAIL landing_state: got %h expected %h", obs, pack(15, 7, 0, 1, 1, 1));
        else n_pass++;
        drive_cycle(0, 0, 0, 8'h01);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 1, 0, 8'h01);
            n_checks++;
            if (obs !== pack(15, 7, 0, 0, 1, 1))
                $display("FAIL landed_ignores_tick %0d: got %h expected %h", i, obs, pack(15, 7, 0, 0, 1, 1));
            else n_pass++;
            drive_cycle(0, 0, 0, 8'h01);
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, i[0], 0, 8'h00);
            n_checks++;
            if (obs !== pack(15, 7, 0, 0, 1, 1))
                $display("FAIL landed_no_lvl_pulse %0d: got %h expected %h", i, obs, pack(15, 7, 0, 0, 1, 1));
            else n_pass++;
        end
    endtask

    task automatic test_wave_clear();
        do_reset();
        drive_cycle(0, 0, 0, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 1, 0, 8'hFF);
            drive_cycle(0, 0, 0, 8'hFF);
        end
        drive_cycle(0, 1, 0, 8'h00);
        n_checks++;
        if (obs !== pack(0, 0, 1, 0, 0, 0))
            $display("FAIL wave_clear_pulse: got %h expected %h", obs, pack(0, 0, 1, 0, 0, 0));
        else n_pass++;
        for (int j = 0; j < 10; j++) begin
            drive_cycle(0, j[0], 0, 8'h00);
            n_checks++;
            if (obs !== pack(0, 0, 1, 0, 1, 0))
                $display("FAIL clear_hold %0d: got %h expected %h", j, obs, pack(0, 0, 1, 0, 1, 0));
            else n_pass++;
        end
        drive_cycle(0, 0, 0, 8'hFF);
        n_checks++;
        if (obs !== pack(0, 0, 1, 0, 1, 0))
            $display("FAIL clear_exit: got %h expected %h", obs, pack(0, 0, 1, 0, 1, 0));
        else n_pass++;
        drive_cycle(0, 1, 0, 8'hFF);
        n_checks++;
        if (obs !== pack(1, 0, 1, 1, 1, 0))
            $display("FAIL march_resume: got %h expected %h", obs, pack(1, 0, 1, 1, 1, 0));
        else n_pass++;
        drive_cycle(0, 0, 0, 8'hFF);
    endtask

    task automatic test_freeze();
        do_reset();
        drive_cycle(0, 0, 0, 8'hFF);
        for (int i = 0; i < 2; i++) begin
            drive_cycle(0, 1, 0, 8'hFF);
            drive_cycle(0, 0, 0, 8'hFF);
        end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 1, 1, 8'hFF);
            n_checks++;
            if (obs !== pack(2, 0, 1, 0, 1, 0))
                $display("FAIL freeze_hold %0d: got %h expected %h", i, obs, pack(2, 0, 1, 0, 1, 0));
            else n_pass++;
            drive_cycle(0, 0, 1, 8'hFF);
        end
        drive_cycle(0, 1, 0, 8'hFF);
        n_checks++;
        if (obs !== pack(3, 0, 1, 1, 1, 0))
            $display("FAIL freeze_release: got %h expected %h", obs, pack(3, 0, 1, 1, 1, 0));
        else n_pass++;
        drive_cycle(0, 0, 0, 8'hFF);
    endtask

    task automatic test_reset_mid();
        int k;
        drive_cycle(1, 1, 0, 8'hFF);
        drive_cycle(0, 1, 0, 8'hFF);
        n_checks++;
        if (obs !== pack(0, 0, 1, 0, 1, 0))
            $display("FAIL no_tick_at_release: got %h expected %h", obs, pack(0, 0, 1, 0, 1, 0));
        else n_pass++;
        for (k = 0; k < 100; k++) begin
            if (x_pos === 5'sd5 && y_pos === 3'd3) break;
            drive_cycle(0, 0, 0, 8'hFF);
            drive_cycle(0, 1, 0, 8'hFF);
        end
        n_checks++;
        if (obs !== pack(5, 3, 0, 1, 1, 0))
            $display("FAIL reach_x5_y3: got %h expected %h", obs, pack(5, 3, 0, 1, 1, 0));
        else n_pass++;
        drive_cycle(1, 1, 0, 8'hFF);
        n_checks++;
        if (obs !== pack(0, 0, 1, 0, 1, 0))
            $display("FAIL mid_reset: got %h expected %h", obs, pack(0, 0, 1, 0, 1, 0));
        else n_pass++;
        drive_cycle(0, 1, 0, 8'hFF);
        n_checks++;
        if (obs !== pack(0, 0, 1, 0, 1, 0))
            $display("FAIL mid_reset_release: got %h expected %h", obs, pack(0, 0, 1, 0, 1, 0));
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] mask;
        bit rst, sc, fr;
        int errs;
        errs = 0;
        mask = 8'hFF;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 3))
                    0: mask = 8'h00;
                    1: mask = 8'h01 << $urandom_range(0, 7);
                    default: mask = 8'($urandom_range(0, 255));
                endcase
            end
            rst = ($urandom_range(0, 299) == 0);
            sc  = ($urandom_range(0, 2) != 0) ? ~step_clk : step_clk;
            fr  = ($urandom_range(0, 9) == 0);
            drive_cycle(rst, sc, fr, mask);
            n_checks++;
            if (obs !== model_vec()) begin
                if (errs < 10)
                    $display("FAIL random cycle %0d: got %h expected %h", c, obs, model_vec());
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_march_right();
        test_left_edge();
        test_landing();
        test_wave_clear();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_invader_march
